uart_tx_fifo: RTL and testbench
===============================

// Module: uart_tx_fifo
// PURPOSE
//  Byte-wide transmit buffer feeding the UART core's tx_data/tx_en inputs.
//  Accepts bytes from the UART register block and holds them in a circular FIFO.
//  Launches one byte at a time to the core, advancing on each tx_done pulse.
//  Lets software queue DEPTH bytes without polling the transmitter per byte.
// PARAMETERS
//  DEPTH   16  FIFO entries; must be a power of two, >= 2
//  ADDR_W  4   log2(DEPTH); pointer width
// PORTS
//  clk_i        in   1         system clock, all state updates on rising edge
//  rst_i        in   1         asynchronous, active-high reset
//  push_i       in   1         write one byte into FIFO this cycle
//  push_data_i  in   8         byte to enqueue
//  flush_i      in   1         discard all queued (not in-flight) bytes
//  ovf_clr_i    in   1         clear sticky overflow flag
//  full_o       out  1         count_o == DEPTH
//  empty_o      out  1         count_o == 0
//  count_o      out  ADDR_W+1  queued bytes, excluding the in-flight byte
//  overflow_o   out  1         sticky: a push was dropped because FIFO was full
//  busy_o       out  1         FSM not in IDLE (a byte is in flight)
//  tx_data_o    out  8         byte presented to UART core
//  tx_en_o      out  1         one-cycle start pulse to UART core
//  tx_done_i    in   1         one-cycle pulse from core: current byte finished
// BEHAVIOUR
//  Reset: all outputs 0, except empty_o=1. Pointers 0, FSM=IDLE.
//  The outputs listed as 0 are count, full, overflow, busy, tx_data and tx_en.
//  Reset mid-transfer abandons the in-flight byte; the core is reset by the same rst_i.
//  Storage: DEPTH x 8 register array; wr_ptr/rd_ptr ADDR_W bits, wrap modulo DEPTH.
//  Count: ADDR_W+1 bits, range 0..DEPTH.
//  Push: accepted iff count_o < DEPTH before the edge. The accepted byte is written at wr_ptr, which then increments.
//  Push while full: byte dropped, count unchanged, overflow_o<=1 at that edge.
//  Overflow clear: overflow_o clears only on ovf_clr_i. If ovf_clr_i and an overflowing push coincide, set wins.
//  Pop: internal, only in IDLE with count_o != 0. Never pops an empty FIFO.
//  Push+pop same edge: count unchanged, both pointers advance. Legal even at count==DEPTH (pop frees the slot).
//  flush_i: wr_ptr=rd_ptr=0 and count=0 at the edge.
//   - Overrides a push and a pop in the same cycle: the push is dropped, overflow is not set, and nothing is launched.
//   - Does not abort an in-flight byte: FSM state, tx_data_o and busy_o are unaffected.
//  FSM states:
//   IDLE: if count!=0 and !flush_i -> tx_data_o<=mem[rd_ptr], rd_ptr++, tx_en_o<=1, go WAIT.
//   WAIT: tx_en_o<=0 (high exactly one cycle); tx_data_o held stable.
//         On tx_done_i -> IDLE.
//  tx_done_i sampled in IDLE is ignored.
//  Latency: push at edge k into empty idle FIFO -> tx_en_o high from edge k+1 to k+2, tx_data_o valid from k+1.
//  Back-to-back: tx_done_i at edge m with count!=0 -> next tx_en_o pulse at edge m+1 (one IDLE cycle).
//  busy_o = (state==WAIT). full_o, empty_o and count_o are registered-state derived, with no comb path from push_i.
// TESTING
//  T1 reset: assert rst_i mid-WAIT with 5 queued -> async: count_o=0, empty_o=1, tx_en_o=0, busy_o=0, overflow_o=0.
//  T2 single byte: push 0xA5 at edge k -> tx_en_o=1 for one cycle from k+1, tx_data_o=0xA5; tx_done_i -> busy_o=0.
//  T3 fill: hold core (no tx_done), push 17 bytes 0x00..0x10 -> first byte in flight, count_o=16, full_o=1.
//     The 18th push is dropped and sets overflow_o=1. Release tx_done 17 times -> output order 0x00..0x10.
//  T4 wrap + simultaneous: count_o=16, tx_done_i then push 0x55 on the pop edge -> count_o stays 16, no overflow.
//     0x55 emerges last after pointer wrap.
//  T5 flush: queue 4 bytes while byte 0x11 in flight, pulse flush_i together with push 0x22 -> count_o=0.
//     0x11 completes; no further tx_en_o; overflow_o=0.
//  T6 overflow clear: overflow_o=1, pulse ovf_clr_i -> 0. ovf_clr_i coinciding with a full push -> stays 1.

Source files
------------

// File: rtl/uart_tx_fifo_if.sv
// Bus between the UART register block / UART core and the transmit FIFO.
// The register block drives slave inputs, the FIFO drives slave outputs.
interface uart_tx_fifo_if #(
  parameter int ADDR_W = 4
);
  // push_i is a valid with no ready: the writer must check full_o beforehand,
  // because a push seen while full_o=1 (and no pop on that edge) is dropped and
  // sets overflow_o. tx_en_o is a one-cycle start strobe to the core; the core
  // answers with a one-cycle tx_done_i, and tx_data_o stays stable in between.
  logic              push_i;
  logic [7:0]        push_data_i;
  logic              flush_i;
  logic              ovf_clr_i;
  logic              tx_done_i;
  logic              full_o;
  logic              empty_o;
  logic [ADDR_W:0]   count_o;
  logic              overflow_o;
  logic              busy_o;
  logic [7:0]        tx_data_o;
  logic              tx_en_o;

  modport slave (
    input  push_i, push_data_i, flush_i, ovf_clr_i, tx_done_i,
    output full_o, empty_o, count_o, overflow_o, busy_o, tx_data_o, tx_en_o
  );

  modport master (
    output push_i, push_data_i, flush_i, ovf_clr_i, tx_done_i,
    input  full_o, empty_o, count_o, overflow_o, busy_o, tx_data_o, tx_en_o
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Circular byte FIFO that launches one byte at a time into the UART core and
// advances on each tx_done pulse. busy_o is the FSM state (WAIT when high).
module uart_tx_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic           clk_i,
  input  logic           rst_i,
  uart_tx_fifo_if.slave  bus
);
  localparam logic [0:0]      S_IDLE   = 1'b0;
  localparam logic [0:0]      S_WAIT   = 1'b1;
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

  logic [7:0]        mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [0:0]        state_q, state_d;
  logic              overflow_q, overflow_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_en_q, tx_en_d;

  logic full, pop, push_ok, ovf_set;

  always_comb begin
    full    = (count_q == FULL_CNT);
    pop     = (state_q == S_IDLE) && (count_q != '0) && !bus.flush_i;
    // A pop on the same edge frees the slot, so a push at full is still taken.
    push_ok = bus.push_i && !bus.flush_i && (!full || pop);
    ovf_set = bus.push_i && !bus.flush_i && full && !pop;
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (bus.flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      if (pop)     rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      if (push_ok && !pop)      count_d = count_q + (ADDR_W + 1)'(1);
      else if (pop && !push_ok) count_d = count_q - (ADDR_W + 1)'(1);
    end
    if (ovf_set)            overflow_d = 1'b1;
    else if (bus.ovf_clr_i) overflow_d = 1'b0;
  end

  // Flush never touches the in-flight byte: state and tx_data follow only pop/done.
  always_comb begin
    state_d   = state_q;
    tx_data_d = tx_data_q;
    tx_en_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          tx_data_d = mem_q[rd_ptr_q];
          tx_en_d   = 1'b1;
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.tx_done_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= S_IDLE;
      overflow_q <= 1'b0;
      tx_data_q  <= 8'h00;
      tx_en_q    <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      state_q    <= state_d;
      overflow_q <= overflow_d;
      tx_data_q  <= tx_data_d;
      tx_en_q    <= tx_en_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= bus.push_data_i;
  end

  assign bus.full_o     = full;
  assign bus.empty_o    = (count_q == '0);
  assign bus.count_o    = count_q;
  assign bus.overflow_o = overflow_q;
  assign bus.busy_o     = (state_q == S_WAIT);
  assign bus.tx_data_o  = tx_data_q;
  assign bus.tx_en_o    = tx_en_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomised bench for uart_tx_fifo against a queue-based model of the buffer,
// plus directed scenarios with literal expectations.
module tb_uart_tx_fifo;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  uart_tx_fifo_if #(.ADDR_W(ADDR_W)) bus ();

  uart_tx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic       m_busy = 1'b0;
  logic       m_ovf  = 1'b0;
  logic       m_en   = 1'b0;
  logic [7:0] m_data = 8'h00;

  task automatic model_step();
    bit launch, take, ovf_hit;
    if (rst) begin
      exp_q.delete();
      m_busy = 1'b0;
      m_ovf  = 1'b0;
      m_en   = 1'b0;
      m_data = 8'h00;
    end else begin
      launch  = !m_busy && exp_q.size() != 0 && !bus.flush_i;
      take    = bus.push_i && !bus.flush_i && (exp_q.size() < DEPTH || launch);
      ovf_hit = bus.push_i && !bus.flush_i && !take;
      if (ovf_hit)            m_ovf = 1'b1;
      else if (bus.ovf_clr_i) m_ovf = 1'b0;
      if (bus.flush_i) exp_q.delete();
      m_en = 1'b0;
      if (launch) begin
        m_data = exp_q.pop_front();
        m_en   = 1'b1;
        m_busy = 1'b1;
      end else if (m_busy && bus.tx_done_i) begin
        m_busy = 1'b0;
      end
      if (take) exp_q.push_back(bus.push_data_i);
    end
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    model_step();
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      chk("cmp_count",    32'(bus.count_o),    32'(exp_q.size()));
      chk("cmp_full",     32'(bus.full_o),     32'(exp_q.size() == DEPTH));
      chk("cmp_empty",    32'(bus.empty_o),    32'(exp_q.size() == 0));
      chk("cmp_overflow", 32'(bus.overflow_o), 32'(m_ovf));
      chk("cmp_busy",     32'(bus.busy_o),     32'(m_busy));
      chk("cmp_tx_en",    32'(bus.tx_en_o),    32'(m_en));
      chk("cmp_tx_data",  32'(bus.tx_data_o),  32'(m_data));
      if (bus.tx_en_o) got_q.push_back(bus.tx_data_o);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input logic p, input logic [7:0] d, input logic dn,
                      input logic fl, input logic cl);
    bus.push_i      = p;
    bus.push_data_i = d;
    bus.tx_done_i   = dn;
    bus.flush_i     = fl;
    bus.ovf_clr_i   = cl;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic release_n(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      idle(2);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    bus.push_i = 1'b0; bus.push_data_i = 8'h00; bus.tx_done_i = 1'b0;
    bus.flush_i = 1'b0; bus.ovf_clr_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_count", 32'(bus.count_o), 0);
    chk("rst_empty", 32'(bus.empty_o), 1);
    chk("rst_full",  32'(bus.full_o),  0);
    chk("rst_tx_en", 32'(bus.tx_en_o), 0);
    chk("rst_busy",  32'(bus.busy_o),  0);
    rst = 1'b0;

    // single byte latency
    step(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
    chk("t2_count_k",   32'(bus.count_o),  1);
    chk("t2_en_k",      32'(bus.tx_en_o),  0);
    idle(1);
    chk("t2_en_k1",     32'(bus.tx_en_o),  1);
    chk("t2_data_k1",   32'(bus.tx_data_o), 32'hA5);
    chk("t2_busy_k1",   32'(bus.busy_o),   1);
    idle(1);
    chk("t2_en_k2",     32'(bus.tx_en_o),  0);
    chk("t2_data_k2",   32'(bus.tx_data_o), 32'hA5);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("t2_busy_done", 32'(bus.busy_o),   0);

    // fill, overflow, overflow clear, ordered drain
    got_q.delete();
    for (int i = 0; i < 17; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
    chk("t3_count16", 32'(bus.count_o), 16);
    chk("t3_full",    32'(bus.full_o),  1);
    chk("t3_busy",    32'(bus.busy_o),  1);
    step(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
    chk("t3_ovf_set",   32'(bus.overflow_o), 1);
    chk("t3_count_ovf", 32'(bus.count_o), 16);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("t6_ovf_clr",   32'(bus.overflow_o), 0);
    step(1'b1, 8'hEF, 1'b0, 1'b0, 1'b1);
    chk("t6_set_wins",  32'(bus.overflow_o), 1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("t6_ovf_clr2",  32'(bus.overflow_o), 0);
    release_n(17);
    #1;
    chk("t3_n_sent", 32'(got_q.size()), 17);
    for (int i = 0; i < 17 && i < got_q.size(); i++)
      chk($sformatf("t3_order_%0d", i), 32'(got_q[i]), 32'(i));

    // wrap with simultaneous push and pop at full
    got_q.delete();
    for (int i = 0; i < 17; i++) step(1'b1, 8'(8'h30 + i), 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("t4_count_pre", 32'(bus.count_o), 16);
    step(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
    chk("t4_count_same", 32'(bus.count_o), 16);
    chk("t4_no_ovf",     32'(bus.overflow_o), 0);
    chk("t4_launch",     32'(bus.tx_data_o), 32'h31);
    release_n(17);
    #1;
    chk("t4_n_sent", 32'(got_q.size()), 18);
    if (got_q.size() == 18) begin
      chk("t4_prev_last", 32'(got_q[16]), 32'h40);
      chk("t4_last_55",   32'(got_q[17]), 32'h55);
    end

    // flush while a byte is in flight
    got_q.delete();
    step(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
    idle(1);
    for (int i = 1; i <= 4; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
    chk("t5_count4", 32'(bus.count_o), 4);
    step(1'b1, 8'h22, 1'b0, 1'b1, 1'b0);
    chk("t5_count0",   32'(bus.count_o),   0);
    chk("t5_busy",     32'(bus.busy_o),    1);
    chk("t5_data",     32'(bus.tx_data_o), 32'h11);
    chk("t5_no_ovf",   32'(bus.overflow_o), 0);
    idle(3);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    idle(5);
    #1;
    chk("t5_n_sent", 32'(got_q.size()), 1);
    chk("t5_idle",   32'(bus.busy_o), 0);

    // asynchronous reset in the middle of a transfer
    for (int i = 1; i <= 6; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
    chk("t1_count5", 32'(bus.count_o), 5);
    chk("t1_busy1",  32'(bus.busy_o), 1);
    #2 rst = 1'b1;
    #1;
    chk("t1_count",  32'(bus.count_o),    0);
    chk("t1_empty",  32'(bus.empty_o),    1);
    chk("t1_tx_en",  32'(bus.tx_en_o),    0);
    chk("t1_busy",   32'(bus.busy_o),     0);
    chk("t1_ovf",    32'(bus.overflow_o), 0);
    chk("t1_data",   32'(bus.tx_data_o),  0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    // randomised traffic in phases of differing push pressure
    for (int seg = 0; seg < 6; seg++) begin
      int push_pct;
      push_pct = (seg % 2 == 0) ? 45 : 10;
      for (int i = 0; i < 500; i++)
        step($urandom_range(0, 99) < push_pct, 8'($urandom_range(0, 255)),
             $urandom_range(0, 3) == 0, $urandom_range(0, 59) == 0,
             $urandom_range(0, 19) == 0);
    end

    for (int i = 0; i < 400; i++) begin
      if (exp_q.size() == 0 && !m_busy) break;
      step(1'b0, 8'h00, i % 2 == 0, 1'b0, 1'b0);
    end
    idle(2);
    chk("drain_empty", 32'(bus.empty_o), 1);
    chk("drain_busy",  32'(bus.busy_o),  0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
